// File: rtl/fwd_hazard_unit_if.sv
// Bundle of the EX-stage forwarding/hazard signals shared between the
// pipeline control (master) and fwd_hazard_unit (slave).
interface fwd_hazard_unit_if #(
    parameter int unsigned NSRC = 2,
    parameter int unsigned NSTG = 2,
    parameter int unsigned REGW = 5
);
    localparam int unsigned SELW = $clog2(NSTG + 1);

    logic [NSRC*REGW-1:0] src_reg;
    logic [NSRC-1:0]      src_valid;
    logic [NSTG*REGW-1:0] stg_dest;
    logic [NSTG-1:0]      stg_wen;
    logic [NSTG-1:0]      stg_ldpend;
    logic                 mem_wait;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall;
    logic [31:0]          hit_cnt;
    logic [31:0]          stall_cnt;

    modport master (
        output src_reg, src_valid, stg_dest, stg_wen, stg_ldpend, mem_wait,
        input  fwd_sel, stall, hit_cnt, stall_cnt
    );

    modport slave (
        input  src_reg, src_valid, stg_dest, stg_wen, stg_ldpend, mem_wait,
        output fwd_sel, stall, hit_cnt, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard unit beside the EX stage: per-operand youngest-producer
// forwarding select, load-use hazard detection and an LDLAT-cycle hold FSM.
// Optional performance counters are built when FWD_PERF_EN is defined;
// otherwise hit_cnt/stall_cnt read constant zero.
module fwd_hazard_unit #(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NSTG  = 2,
    parameter int unsigned REGW  = 5,
    parameter int unsigned LDLAT = 1
) (
    input  logic                CLK,
    input  logic                RST,
    fwd_hazard_unit_if.slave    bus
);
    localparam int unsigned SELW = $clog2(NSTG + 1);
    localparam int unsigned CNTW = (LDLAT > 1) ? $clog2(LDLAT) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [NSRC-1:0]      found;
    logic [NSRC*SELW-1:0] sel_raw;
    logic                 hazard;
    logic                 stall_int;

    // Youngest matching producer per operand; hazard if that producer's load is pending.
    always_comb begin
        found   = '0;
        sel_raw = '0;
        hazard  = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                if (!found[i] &&
                    bus.src_valid[i] &&
                    bus.stg_wen[s] &&
                    (bus.stg_dest[s*REGW +: REGW] == bus.src_reg[i*REGW +: REGW]) &&
                    (bus.src_reg[i*REGW +: REGW] != '0)) begin
                    found[i]                 = 1'b1;
                    sel_raw[i*SELW +: SELW]  = SELW'(s + 1);
                    if (bus.stg_ldpend[s]) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_int   = (state_q == HOLD) || hazard;
    assign bus.stall   = !RST && stall_int;
    assign bus.fwd_sel = RST ? '0 : sel_raw;

    // Hold FSM next state; mem_wait freezes both state and count.
    // Detection cycle counts as the first stall cycle, so HOLD is left on the
    // decrement that reaches zero, giving LDLAT stall cycles in total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hazard && !bus.mem_wait) begin
                    cnt_d = CNTW'(LDLAT - 1);
                    if (LDLAT > 1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!bus.mem_wait) begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Hold FSM registers, asynchronously cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FWD_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] nhit;

    // Count forwarded operands on advancing cycles and stall cycles on unfrozen cycles.
    always_comb begin
        nhit        = '0;
        hit_cnt_d   = hit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel_raw[i*SELW +: SELW] != '0) begin
                nhit = nhit + 32'd1;
            end
        end
        if (!bus.mem_wait) begin
            if (stall_int) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + nhit;
            end
        end
    end

    // Performance counter registers, wrapping at 2^32.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.hit_cnt   = '0;
    assign bus.stall_cnt = '0;
`endif

endmodule
